// File: rtl/bus_arbiter.sv
// Multi-master to single-slave bus arbiter.
// Fixed-priority or round-robin grant with a per-transfer timeout abort.
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_MASTERS-1:0]        HTRANS,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR,
  input  logic [NUM_MASTERS-1:0]        HWRITE,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA,
  output logic [NUM_MASTERS-1:0]        HREADY,
  output logic                          HERR,
  output logic [DATA_W-1:0]             HRDATA,
  output logic [NUM_MASTERS-1:0]        stall,
  output logic                          PSEL,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PWDATA,
  input  logic                          PREADY,
  input  logic [DATA_W-1:0]             PRDATA
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = GW + 1;
  localparam logic [SW-1:0] NM = SW'(NUM_MASTERS);
  localparam logic [GW-1:0] LAST = GW'(NUM_MASTERS - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [GW-1:0] grant, ptr, base, off, win;
  logic [SW-1:0] sum;
  logic [NUM_MASTERS-1:0] rot;
  logic [7:0] cnt;
  logic err, tmo;
  logic [ADDR_W-1:0] sel_addr;
  logic sel_write;
  logic [DATA_W-1:0] sel_wdata;

  assign base = (RR_MODE != 0) ? ptr : '0;

  // Rotate requests so the search always starts at bit 0, then undo it.
  always_comb begin
    rot = NUM_MASTERS'({HTRANS, HTRANS} >> base);
    off = '0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (rot[j]) off = GW'(j);
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NM) sum = sum - NM;
    win = sum[GW-1:0];
  end

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win == GW'(i)) begin
        sel_addr  = HADDR[i*ADDR_W +: ADDR_W];
        sel_write = HWRITE[i];
        sel_wdata = HWDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign tmo = !PREADY && (cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|HTRANS) state_nxt = BUSY;
      BUSY: if (PREADY || tmo) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      grant  <= '0;
      ptr    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      HRDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|HTRANS) begin
            grant  <= win;
            PADDR  <= sel_addr;
            PWRITE <= sel_write;
            PWDATA <= sel_wdata;
            cnt    <= '0;
            err    <= 1'b0;
          end
        end
        BUSY: begin
          if (PREADY) begin
            if (!PWRITE) HRDATA <= PRDATA;
          end else if (tmo) begin
            HRDATA <= '1;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
          if (PREADY || tmo)
            ptr <= (grant == LAST) ? '0 : grant + GW'(1);
        end
        default: ;
      endcase
    end
  end

  assign PSEL   = (state == BUSY);
  assign HREADY = (state == DONE) ? (NUM_MASTERS'(1) << grant) : '0;
  assign HERR   = (state == DONE) && err;
  assign stall  = HTRANS & ~HREADY;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: fixed-priority and round-robin instances
// share stimulus and are checked against a transaction-level model.
module tb_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic [N-1:0] HTRANS = '0;
  logic [N-1:0] HWRITE = '0;
  logic [N*AW-1:0] HADDR = '0;
  logic [N*DW-1:0] HWDATA = '0;
  logic PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;

  logic [N-1:0] f_hready, f_stall, r_hready, r_stall;
  logic f_herr, f_psel, f_pwrite, r_herr, r_psel, r_pwrite;
  logic [DW-1:0] f_hrdata, f_pwdata, r_hrdata, r_pwdata;
  logic [AW-1:0] f_paddr, r_paddr;

  int checks = 0;
  int failures = 0;
  int rr_ptr = 0;
  logic [DW-1:0] f_hr = '0;
  logic [DW-1:0] r_hr = '0;

  always #5 CLK = ~CLK;

  bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(0), .TIMEOUT(TO)
  ) u_fix (
    .CLK(CLK), .RESET(RESET),
    .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(f_hready), .HERR(f_herr),
    .HRDATA(f_hrdata), .stall(f_stall),
    .PSEL(f_psel), .PADDR(f_paddr),
    .PWRITE(f_pwrite), .PWDATA(f_pwdata),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(1), .TIMEOUT(TO)
  ) u_rr (
    .CLK(CLK), .RESET(RESET),
    .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(r_hready), .HERR(r_herr),
    .HRDATA(r_hrdata), .stall(r_stall),
    .PSEL(r_psel), .PADDR(r_paddr),
    .PWRITE(r_pwrite), .PWDATA(r_pwdata),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  function automatic int win_fixed(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (1'(r >> i)) return i;
    return 0;
  endfunction

  function automatic int win_rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (1'(r >> ((p + k) % N))) return (p + k) % N;
    return 0;
  endfunction

  task automatic randomize_masters();
    for (int i = 0; i < N; i++) begin
      HADDR[i*AW +: AW] = AW'($urandom);
      HWDATA[i*DW +: DW] = $urandom;
    end
    HWRITE = N'($urandom);
  endtask

  // One transfer from the IDLE negedge through DONE back to IDLE.
  task automatic do_txn(input logic [N-1:0] req, input int w,
                        input bit drop, input bit rnd,
                        input logic [DW-1:0] rd);
    int wf, wr, b;
    bit fin, terr, rdy;
    logic [AW-1:0] ea_f, ea_r;
    logic ew_f, ew_r;
    logic [DW-1:0] ed_f, ed_r, last_rd;
    logic [N-1:0] mf, mr;
    if (rnd) randomize_masters();
    HTRANS = req;
    PREADY = 1'($urandom);
    wf = win_fixed(req);
    wr = win_rr(req, rr_ptr);
    ea_f = AW'(HADDR >> (wf * AW));
    ea_r = AW'(HADDR >> (wr * AW));
    ew_f = 1'(HWRITE >> wf);
    ew_r = 1'(HWRITE >> wr);
    ed_f = DW'(HWDATA >> (wf * DW));
    ed_r = DW'(HWDATA >> (wr * DW));
    last_rd = '0;
    terr = 1'b0;
    fin = 1'b0;
    b = 0;
    @(posedge CLK); @(negedge CLK);
    while (!fin) begin
      b++;
      checks++;
      if ({f_psel, f_paddr, f_pwrite, f_pwdata, f_hready} !==
          {1'b1, ea_f, ew_f, ed_f, {N{1'b0}}}) begin
        failures++;
        $display("FAIL busy_fix b=%0d got=%h exp=%h", b,
          {f_psel, f_paddr, f_pwrite, f_pwdata, f_hready},
          {1'b1, ea_f, ew_f, ed_f, {N{1'b0}}});
      end
      checks++;
      if ({r_psel, r_paddr, r_pwrite, r_pwdata, r_hready} !==
          {1'b1, ea_r, ew_r, ed_r, {N{1'b0}}}) begin
        failures++;
        $display("FAIL busy_rr b=%0d got=%h exp=%h", b,
          {r_psel, r_paddr, r_pwrite, r_pwdata, r_hready},
          {1'b1, ea_r, ew_r, ed_r, {N{1'b0}}});
      end
      checks++;
      if ({f_stall, r_stall} !== {HTRANS, HTRANS}) begin
        failures++;
        $display("FAIL busy_stall got=%b exp=%b",
          {f_stall, r_stall}, {HTRANS, HTRANS});
      end
      if (rnd) randomize_masters();
      if (drop) HTRANS = '0;
      rdy = (b == w + 1);
      PREADY = rdy;
      PRDATA = rnd ? $urandom : rd;
      last_rd = PRDATA;
      @(posedge CLK); @(negedge CLK);
      if (rdy) fin = 1'b1;
      else if (b == TO) begin
        fin = 1'b1;
        terr = 1'b1;
      end
    end
    if (terr) begin
      f_hr = '1;
      r_hr = '1;
    end else begin
      if (!ew_f) f_hr = last_rd;
      if (!ew_r) r_hr = last_rd;
    end
    rr_ptr = (wr + 1) % N;
    mf = N'(1) << wf;
    mr = N'(1) << wr;
    checks++;
    if ({f_psel, f_hready, f_herr, f_hrdata, f_stall} !==
        {1'b0, mf, terr, f_hr, HTRANS & ~mf}) begin
      failures++;
      $display("FAIL done_fix got=%h exp=%h",
        {f_psel, f_hready, f_herr, f_hrdata, f_stall},
        {1'b0, mf, terr, f_hr, HTRANS & ~mf});
    end
    checks++;
    if ({r_psel, r_hready, r_herr, r_hrdata, r_stall} !==
        {1'b0, mr, terr, r_hr, HTRANS & ~mr}) begin
      failures++;
      $display("FAIL done_rr got=%h exp=%h",
        {r_psel, r_hready, r_herr, r_hrdata, r_stall},
        {1'b0, mr, terr, r_hr, HTRANS & ~mr});
    end
    PREADY = 1'($urandom);
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({f_psel, f_hready, r_psel, r_hready, f_stall, r_stall} !==
        {1'b0, {N{1'b0}}, 1'b0, {N{1'b0}}, HTRANS, HTRANS}) begin
      failures++;
      $display("FAIL idle_after got=%h exp=%h",
        {f_psel, f_hready, r_psel, r_hready, f_stall, r_stall},
        {1'b0, {N{1'b0}}, 1'b0, {N{1'b0}}, HTRANS, HTRANS});
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    HTRANS = '1;
    PREADY = 1'b1;
    #1;
    checks++;
    if ({f_psel, f_hready, f_herr, f_paddr, f_pwrite, f_pwdata,
         f_hrdata, r_psel, r_hready, r_herr, r_paddr, r_pwrite,
         r_pwdata, r_hrdata} !== '0) begin
      failures++;
      $display("FAIL reset_vals got=%h exp=0",
        {f_psel, f_hready, f_herr, f_paddr, f_pwrite, f_pwdata,
         f_hrdata, r_psel, r_hready, r_herr, r_paddr, r_pwrite,
         r_pwdata, r_hrdata});
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({f_psel, f_hready, r_psel, r_hready} !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0",
        {f_psel, f_hready, r_psel, r_hready});
    end
    RESET = 1'b1;
    HTRANS = '0;
    PREADY = 1'b0;
    rr_ptr = 0;
    f_hr = '0;
    r_hr = '0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_txn(3'b011, 0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++)
      do_txn(3'b111, 0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_read_data();
    HADDR[1*AW +: AW] = 16'h0080;
    HWRITE = 3'b000;
    do_txn(3'b010, 2, 1'b0, 1'b0, 32'hDEADBEEF);
    checks++;
    if ({f_hrdata, r_hrdata} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL read_data got=%h exp=deadbeef", f_hrdata);
    end
  endtask

  task automatic test_timeout();
    do_txn(3'b100, TO, 1'b0, 1'b1, '0);
    do_txn(3'b110, TO + 3, 1'b0, 1'b1, '0);
    do_txn(3'b001, TO - 1, 1'b0, 1'b1, '0);
  endtask

  task automatic test_drop();
    do_txn(3'b010, 0, 1'b1, 1'b1, '0);
    do_txn(3'b101, 2, 1'b1, 1'b1, '0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      HTRANS = '0;
      PREADY = 1'($urandom);
      randomize_masters();
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({f_psel, f_hready, f_stall, r_psel, r_hready, r_stall}
          !== '0) begin
        failures++;
        $display("FAIL idle got=%h exp=0",
          {f_psel, f_hready, f_stall, r_psel, r_hready, r_stall});
      end
    end
  endtask

  task automatic test_reset_busy();
    do_txn(3'b001, 0, 1'b0, 1'b1, '0);
    randomize_masters();
    HTRANS = 3'b111;
    PREADY = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({f_psel, r_psel} !== 2'b11) begin
      failures++;
      $display("FAIL rst_busy_pre got=%b exp=11", {f_psel, r_psel});
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({f_psel, f_hready, f_paddr, r_psel, r_hready, r_paddr}
        !== '0) begin
      failures++;
      $display("FAIL rst_busy_now got=%h exp=0",
        {f_psel, f_hready, f_paddr, r_psel, r_hready, r_paddr});
    end
    PREADY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RESET = 1'b1;
    PREADY = 1'b0;
    rr_ptr = 0;
    f_hr = '0;
    r_hr = '0;
    checks++;
    if ({f_psel, f_hready, r_psel, r_hready, f_hrdata} !== '0) begin
      failures++;
      $display("FAIL rst_busy_after got=%h exp=0",
        {f_psel, f_hready, r_psel, r_hready, f_hrdata});
    end
    do_txn(3'b111, 0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_txn(N'($urandom_range(1, 7)), $urandom_range(0, TO + 1),
             ($urandom_range(0, 3) == 0), 1'b1, '0);
      if ($urandom_range(0, 4) == 0) test_idle();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_read_data();
    test_timeout();
    test_drop();
    test_idle();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of requesting masters; legal range 1..8.
REQ-002 Parameter ADDR_W, default 64: address width.
REQ-003 Parameter DATA_W, default 64: data width.
REQ-004 Parameter RR_MODE, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
REQ-005 Parameter TIMEOUT, default 15: maximum BUSY cycles without PREADY before abort; legal range 1..255.
REQ-006 CLK  input  1  system clock; all state updates on rising edge.
REQ-007 RESET  input  1  asynchronous, active-low reset.
REQ-008 HTRANS  input  NUM_MASTERS  per-master request, held until that master's HREADY.
REQ-009 HADDR  input  NUM_MASTERS*ADDR_W  per-master address; master i uses slice [i*ADDR_W +: ADDR_W].
REQ-010 HWRITE  input  NUM_MASTERS  per-master write flag; 1 = write.
REQ-011 HWDATA  input  NUM_MASTERS*DATA_W  per-master write data, sliced like HADDR.
REQ-012 HREADY  output  NUM_MASTERS  one-cycle completion pulse to the served master.
REQ-013 HERR  output  1  one-cycle pulse coincident with HREADY when the transfer timed out.
REQ-014 HRDATA  output  DATA_W  registered read data for the completed transfer.
REQ-015 stall  output  NUM_MASTERS  master i is requesting and not completing this cycle.
REQ-016 PSEL  output  1  downstream transfer active.
REQ-017 PADDR  output  ADDR_W  registered downstream address.
REQ-018 PWRITE  output  1  registered downstream write flag.
REQ-019 PWDATA  output  DATA_W  registered downstream write data.
REQ-020 PREADY  input  1  downstream completion; sampled only while PSEL=1.
REQ-021 PRDATA  input  DATA_W  downstream read data, valid when PREADY=1.

Function
REQ-022 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-023 In IDLE with any HTRANS bit set, the block SHALL select one winner, latch its HADDR/HWRITE/HWDATA into PADDR/PWRITE/PWDATA, record its index as the grant, set PSEL=1 and enter BUSY on the next edge.
REQ-024 With RR_MODE=0 the winner SHALL be the lowest-index requester.
REQ-025 With RR_MODE=1 the winner SHALL be the first requester at or after the pointer, searching upward with wrap-around modulo NUM_MASTERS.
REQ-026 The pointer SHALL become grant+1, wrapping modulo NUM_MASTERS, when DONE is entered.
REQ-027 In BUSY with PREADY=1, the block SHALL register PRDATA into HRDATA (reads only; writes leave HRDATA unchanged), clear PSEL and enter DONE.
REQ-028 In BUSY, a timeout counter SHALL count from 0 each cycle PREADY=0.
REQ-029 When the counter reaches TIMEOUT, the block SHALL clear PSEL, set HRDATA to all-ones, flag the error and enter DONE.
REQ-030 In DONE, HREADY[grant] SHALL be 1 for exactly one cycle, HERR SHALL be 1 if the error was flagged, and the FSM SHALL return to IDLE.
REQ-031 Minimum latency SHALL be 3 cycles from HTRANS sampled in IDLE to HREADY: grant edge, PREADY in the first BUSY cycle, then DONE.
REQ-032 stall[i] SHALL be combinational: HTRANS[i] AND NOT HREADY[i].
REQ-033 If a granted master drops HTRANS during BUSY, the transfer SHALL still complete and its HREADY SHALL still pulse.
REQ-034 Inputs from non-granted masters SHALL NOT affect PADDR/PWRITE/PWDATA while in BUSY.
REQ-035 The block SHALL NOT re-arbitrate in DONE; a master still requesting after its HREADY is treated as a new request in the following IDLE.
REQ-036 PREADY outside BUSY SHALL be ignored.
REQ-037 With NUM_MASTERS=1, the block SHALL behave as a registered pass-through with the same FSM.

Reset
REQ-038 While RESET=0, the block SHALL asynchronously force: FSM=IDLE; PSEL=0; HREADY=0; HERR=0; PADDR=0; PWRITE=0; PWDATA=0; HRDATA=0; pointer=0; timeout counter=0; grant=0.
REQ-039 Reset asserted mid-BUSY SHALL abort the transfer with no HREADY pulse, and PSEL SHALL drop in the same cycle.
REQ-040 After RESET is released, the first arbitration SHALL occur on the first rising edge with HTRANS nonzero.

Verification
REQ-041 RR_MODE=0, HTRANS=2'b11 held, PREADY=1 always -> master 0 is served every transfer; stall[1]=1 throughout; HREADY[0] pulses every 3 cycles.
REQ-042 RR_MODE=1, HTRANS=2'b11 held -> HREADY alternates 0,1,0,1; PADDR alternates between HADDR slices.
REQ-043 Master 1 read at HADDR=0x80, PRDATA=0xDEADBEEF with PREADY after 2 BUSY cycles -> HRDATA=0xDEADBEEF when HREADY[1]=1; HERR=0.
REQ-044 TIMEOUT=4, PREADY held 0 -> PSEL drops after 4 BUSY cycles; HERR=1 and HREADY pulse together; HRDATA=all-ones.
REQ-045 RESET pulled low during BUSY -> PSEL=0 immediately, no HREADY pulse; after release with RR_MODE=1, master 0 wins first.
REQ-046 Granted master drops HTRANS the cycle after grant -> transfer completes and HREADY still pulses for that master.
